// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register: only this register is reset, the array is not.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data.
// Define SYNC_FIFO_COUNT_EN to add the registered fifo_count occupancy output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic                     wr_en,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [DATA_W-1:0]        data_out
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   fifo_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en && !fifo_empty;
  assign wr_acc = wr_en && (!fifo_full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (data_out)
  );

`ifdef SYNC_FIFO_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   fifo_count <= fifo_count + PTR_W'(1);
        2'b01:   fifo_count <= fifo_count - PTR_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
`else
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              wr_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] data_out;
`ifdef SYNC_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] fifo_count;
`endif

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] model_dout;
  int                n_tests;
  int                n_fail;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .data_in    (data_in),
    .rst        (rst),
    .clk        (clk),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .data_out   (data_out)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the model apply the same edge, then compare.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DATA_W-1:0] din);
    logic racc;
    logic wacc;
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    data_in = w ? din : 'x;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      racc = rd && (model_q.size() != 0);
      wacc = w && ((model_q.size() < DEPTH) || racc);
      if (racc) model_dout = model_q.pop_front();
      if (wacc) model_q.push_back(din);
    end
    #1;
    chk("empty", 32'(fifo_empty), 32'(model_q.size() == 0));
    chk("full",  32'(fifo_full),  32'(model_q.size() == DEPTH));
    chk("dout",  32'(data_out),   32'(model_dout));
`ifdef SYNC_FIFO_COUNT_EN
    chk("count", 32'(fifo_count), 32'(model_q.size()));
`endif
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    model_dout = '0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;

    // Reset held for two cycles
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_dout", 32'(data_out), 32'h0);

    // Fill past capacity, then drain past empty
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, DATA_W'(i));
    chk("fill_full", 32'(fifo_full), 32'h1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("drain_hold", 32'(data_out), 32'd15);

    // Interleaved writes and reads across the pointer wrap
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'(i % 2), DATA_W'(30 + i));
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_last", 32'(data_out), 32'd59);

    // Simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DATA_W'(100 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, DATA_W'(200 + i));
    chk("simul_full", 32'(fifo_full), 32'h1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous read/write while empty: write only, no fall-through
    step(1'b0, 1'b1, 1'b1, 8'h77);
    chk("simul_empty", 32'(fifo_empty), 32'h0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("simul_empty_rd", 32'(data_out), 32'h77);

    // Reset in the middle of operation
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DATA_W'(i + 1));
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("midrst_a5", 32'(data_out), 32'hA5);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), DATA_W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
